// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider: quotient feeds ZLO, remainder feeds ZHI.
// Optional feature macro DIV_UNSIGNED_EN adds a div_unsigned input selecting unsigned division.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

`ifdef DIV_UNSIGNED_EN
    // Unsigned divisors reach 2^WIDTH-1, so the partial remainder needs one extra bit of headroom.
    localparam int RW = WIDTH + 2;
    logic uns_reg;
`else
    localparam int RW = WIDTH + 1;
    localparam logic uns_reg = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] q_reg, d_reg;
    logic [RW-1:0]    r_reg;
    logic [CW-1:0]    cnt;
    logic             sq, sr;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, r_mag;
    logic [RW-1:0]    d_ext, r_shift, r_step;

    assign accept  = start && (state == IDLE || state == DONE);
    assign a_neg   = a_reg[WIDTH-1] && !uns_reg;
    assign b_neg   = b_reg[WIDTH-1] && !uns_reg;
    assign a_abs   = a_neg ? -a_reg : a_reg;
    assign b_abs   = b_neg ? -b_reg : b_reg;
    assign d_ext   = {{(RW-WIDTH){1'b0}}, d_reg};
    assign r_shift = {r_reg[RW-2:0], q_reg[WIDTH-1]};
    assign r_step  = r_reg[RW-1] ? r_shift + d_ext : r_shift - d_ext;
    // Final remainder fits in WIDTH bits once the negative correction is applied.
    assign r_mag   = r_reg[RW-1] ? r_reg[WIDTH-1:0] + d_reg : r_reg[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = (b_reg == '0) ? DONE : ITER;
            ITER:    if (cnt == CW'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = start ? PREP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == PREP) || (state == ITER) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_UNSIGNED_EN
            uns_reg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_reg       <= dividend;
                        b_reg       <= divisor;
                        div_by_zero <= 1'b0;
`ifdef DIV_UNSIGNED_EN
                        uns_reg     <= div_unsigned;
`endif
                    end
                end
                PREP: begin
                    q_reg <= a_abs;
                    d_reg <= b_abs;
                    r_reg <= '0;
                    cnt   <= '0;
                    sq    <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) && !uns_reg;
                    sr    <= a_neg;
                    if (b_reg == '0) begin
                        quotient    <= '1;
                        remainder   <= a_reg;
                        div_by_zero <= 1'b1;
                    end
                end
                ITER: begin
                    r_reg <= r_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~r_step[RW-1]};
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= sq ? -q_reg : q_reg;
                    remainder <= sr ? -r_mag : r_mag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the Mini-SRC ALU datapath.
- Consumes the same operand buses (A, B) that feed the ripple adder.
- Reuses a WIDTH+1-bit add/sub step once per iteration (non-restoring algorithm).
- Quotient goes to the LO half of Z and remainder to the HI half of Z, loaded by the control unit on done.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
dividend  input  WIDTH  A operand, two's complement
divisor  input  WIDTH  B operand, two's complement
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  to ZLO
remainder  output  WIDTH  to ZHI
div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. busy, done, div_by_zero, quotient and remainder all read 0.
- Reset mid-operation aborts the division immediately. No partial result is ever presented.
- States:
  - IDLE→PREP when start=1. Operands are latched at this edge (E0) and busy goes to 1.
  - PREP (E1): latch |dividend| into Q, |divisor| into D, R=0, count=0. Record sq = sign(dividend)^sign(divisor) and sr = sign(dividend).
    - If divisor==0, go to DONE instead of ITER.
  - ITER (E2..E(WIDTH+1)): one step per edge.
    - R' = {R[WIDTH-1:0], Q[WIDTH-1]} − D if R≥0, else + D. R is WIDTH+1 bits signed.
    - Q' = {Q[WIDTH-2:0], ~R'[WIDTH]}.
    - After WIDTH steps, go to FIX.
  - FIX (E(WIDTH+2)):
    - If R<0, R+=D.
    - Apply signs: quotient = sq ? −Q : Q; remainder = sr ? −R : R.
    - Register both outputs, done=1, busy=0, then go to DONE.
  - DONE: lasts exactly one cycle. Goes to PREP if start=1, else to IDLE. done is low again after this cycle.
- Latency: done is high in the cycle after edge E(WIDTH+2), i.e. WIDTH+2 edges after the start edge (34 for WIDTH=32).
- Divide by zero: path is E0→PREP, E1→DONE. Then done=1, div_by_zero=1, quotient = all ones, remainder = dividend.
- div_by_zero clears on the next accepted start.
- Semantics: truncation toward zero. Remainder takes the sign of the dividend. Invariant: dividend = quotient*divisor + remainder, mod 2^WIDTH.
- Overflow case: −2^(WIDTH−1) / −1 gives quotient 0x80000000 (wraps) and remainder 0. No flag is raised.
- start while busy=1 is ignored; in-flight operands are unaffected.
- quotient, remainder and div_by_zero hold their values until the next FIX or divide-by-zero DONE, or until reset.
- Inputs are don't-care after E0.

Optional Feature:
- DIV_UNSIGNED_EN
- Defined: adds input port div_unsigned (1 bit), sampled at E0.
  - When div_unsigned=1, operands are treated as unsigned: no magnitude conversion, sq=sr=0.
  - Divide-by-zero behaviour is unchanged.
- Undefined: port absent; always signed division.

Test Plan:
- 100 / 7 → quotient=14 (0x0000000E), remainder=2. done exactly 34 cycles after start, busy low with done.
- −100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Also 100 / −7 → quotient=0xFFFFFFF2, remainder=2.
- 7 / 0 → done 2 cycles after start, div_by_zero=1, quotient=0xFFFFFFFF, remainder=7. The next 9/3 gives quotient=3, remainder=0, div_by_zero=0.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Also 0x80000000 / 1 → quotient=0x80000000, remainder=0.
- Start 1000/10, pulse start again with 5/5 during ITER, then deassert rst_n at iteration 10.
  - The second start is ignored.
  - Reset gives busy=0 and all outputs 0.
  - The following 50/5 gives quotient=10, remainder=0.
- Back-to-back: start held high from DONE → second division accepted in the DONE cycle and completes 34 cycles later. With DIV_UNSIGNED_EN and div_unsigned=1: 0xFFFFFFFF / 2 → quotient=0x7FFFFFFF, remainder=1.
